// File: rtl/acos_pkg.sv
// Shared constants, mode encoding and elaboration-time table helpers for acos_interp.
package acos_pkg;

    typedef enum logic {
        MODE_ACOS = 1'b0,
        MODE_ASIN = 1'b1
    } mode_e;

    localparam int LATENCY           = 4;
    localparam int DEF_IN_WIDTH      = 32;
    localparam int DEF_OUT_WIDTH     = 32;
    localparam int DEF_IDX_BITS      = 8;
    localparam int DEF_OUT_SCALE     = 5000;
    localparam int DEF_TAG_WIDTH     = 4;
    localparam real ACOS_PI          = 3.14159265358979323846;

    // Newton square root, only ever evaluated at elaboration time.
    function automatic real acos_sqrt(input real v);
        real s;
        s = 1.0;
        if (v <= 0.0) begin
            s = 0.0;
        end else begin
            for (int n = 32'sd0; n < 32'sd40; n++) begin
                s = 0.5 * (s + v / s);
            end
        end
        return s;
    endfunction

    // acos(x) = 2*asin(sqrt((1-|x|)/2)), mirrored for negative x; the asin
    // argument never exceeds 0.7071 so the power series converges quickly.
    function automatic real acos_eval(input real x);
        real ax;
        real y2;
        real p;
        real sum;
        real r;
        ax  = (x < 0.0) ? -x : x;
        y2  = (1.0 - ax) / 2.0;
        p   = acos_sqrt(y2);
        sum = p;
        for (int n = 32'sd1; n < 32'sd60; n++) begin
            p   = p * y2 * real'(2 * n - 1) / real'(2 * n);
            sum = sum + p / real'(2 * n + 1);
        end
        r = 2.0 * sum;
        if (x < 0.0) begin
            r = ACOS_PI - r;
        end
        return r;
    endfunction

    // Table entry k: round(scale * acos(2k/2^idx_bits - 1) / pi).
    function automatic int acos_table_entry(input int k, input int idx_bits, input int scale);
        real x;
        x = 2.0 * real'(k) / real'(32'sd1 << idx_bits) - 1.0;
        return $rtoi(real'(scale) * acos_eval(x) / ACOS_PI + 0.5);
    endfunction

endpackage

// File: rtl/acos_interp_mul.sv
// Registered signed multiplier with enable; product is the full A_W+B_W width.
module acos_interp_mul #(
    parameter int A_W = 32,
    parameter int B_W = 25
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      en_i,
    input  logic signed [A_W-1:0]     a_i,
    input  logic signed [B_W-1:0]     b_i,
    output logic signed [A_W+B_W-1:0] p_o
);

    logic signed [A_W+B_W-1:0] p_q;

    // Capture the signed product when the pipeline advances.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= a_i * b_i;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/acos_lut.sv
// Dual-read-port arccos table with registered outputs and a shared read enable.
// Entries are fixed at elaboration; entry 2^IDX_BITS (value 0) is present so
// the last interval interpolates towards zero without index wrap.
module acos_lut
    import acos_pkg::*;
#(
    parameter int IDX_BITS  = DEF_IDX_BITS,
    parameter int DATA_W    = DEF_OUT_WIDTH,
    parameter int OUT_SCALE = DEF_OUT_SCALE
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rd_en_i,
    input  logic [IDX_BITS:0] rd_addr_a_i,
    input  logic [IDX_BITS:0] rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o
);

    localparam int DEPTH = (32'sd1 << IDX_BITS) + 32'sd1;

    logic [DATA_W-1:0] rom_s [DEPTH];
    logic [DATA_W-1:0] data_a_q;
    logic [DATA_W-1:0] data_b_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [DATA_W-1:0] ENTRY = DATA_W'(acos_table_entry(k, IDX_BITS, OUT_SCALE));
        assign rom_s[k] = ENTRY;
    end

    // Registered read of both table ports when the pipeline advances.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else if (rd_en_i) begin
            data_a_q <= rom_s[rd_addr_a_i];
            data_b_q <= rom_s[rd_addr_b_i];
        end
    end

    assign rd_data_a_o = data_a_q;
    assign rd_data_b_o = data_b_q;

endmodule

// File: rtl/acos_interp.sv
// Four-stage interpolated arccos/arcsin pipeline with valid/ready flow control.
// Output is scaled so OUT_SCALE represents pi; asin is derived as pi/2 - acos.
module acos_interp
    import acos_pkg::*;
#(
    parameter int    IN_WIDTH  = DEF_IN_WIDTH,
    parameter int    OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int    IDX_BITS  = DEF_IDX_BITS,
    parameter int    OUT_SCALE = DEF_OUT_SCALE,
    parameter int    TAG_WIDTH = DEF_TAG_WIDTH,
    parameter string LUT_FILE  = "acos_lut.mem"
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [IN_WIDTH-1:0]         acos_in,
    input  logic                        mode_in,
    input  logic [TAG_WIDTH-1:0]        tag_in,
    input  logic                        valid_in,
    output logic                        ready_in,
    output logic signed [OUT_WIDTH-1:0] result_out,
    output logic [TAG_WIDTH-1:0]        tag_out,
    output logic                        valid_out,
    input  logic                        ready_out
);

    localparam int FRAC_BITS = IN_WIDTH - IDX_BITS;
    localparam int PROD_W    = OUT_WIDTH + FRAC_BITS + 1;
    localparam logic signed [OUT_WIDTH-1:0] HALF_SCALE = OUT_WIDTH'(OUT_SCALE / 2);

    // Global advance: every stage moves together unless the output is held.
    logic adv_s;

    // Stage 1
    logic                 s1_valid_q;
    logic [IDX_BITS-1:0]  s1_idx_q;
    logic [FRAC_BITS-1:0] s1_frac_q;
    mode_e                s1_mode_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;
    logic [IDX_BITS:0]    addr_a_s;
    logic [IDX_BITS:0]    addr_b_s;

    // Stage 2
    logic                 s2_valid_q;
    logic [FRAC_BITS-1:0] s2_frac_q;
    mode_e                s2_mode_q;
    logic [TAG_WIDTH-1:0] s2_tag_q;
    logic [OUT_WIDTH-1:0] lut_a_s;
    logic [OUT_WIDTH-1:0] lut_b_s;
    logic signed [OUT_WIDTH-1:0]   diff_s;
    logic signed [FRAC_BITS:0]     frac_signed_s;

    // Stage 3
    logic                        s3_valid_q;
    logic signed [OUT_WIDTH-1:0] s3_base_q;
    mode_e                       s3_mode_q;
    logic [TAG_WIDTH-1:0]        s3_tag_q;
    logic signed [PROD_W-1:0]    s3_prod_s;

    // Stage 4 (output)
    logic signed [OUT_WIDTH-1:0] interp_s;
    logic signed [OUT_WIDTH-1:0] result_d;
    logic signed [OUT_WIDTH-1:0] result_q;
    logic [TAG_WIDTH-1:0]        tag_q;
    logic                        valid_q;

    assign adv_s    = ready_out || !valid_q;
    assign ready_in = adv_s;

    // Stage 1: split the code into table index and fraction, keep mode and tag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_frac_q  <= '0;
            s1_mode_q  <= MODE_ACOS;
            s1_tag_q   <= '0;
        end else if (adv_s) begin
            s1_valid_q <= valid_in;
            s1_idx_q   <= acos_in[IN_WIDTH-1:FRAC_BITS];
            s1_frac_q  <= acos_in[FRAC_BITS-1:0];
            s1_mode_q  <= mode_e'(mode_in);
            s1_tag_q   <= tag_in;
        end
    end

    // Neighbouring entries; the +1 address is one bit wider so it reaches the end entry.
    assign addr_a_s = {1'b0, s1_idx_q};
    assign addr_b_s = {1'b0, s1_idx_q} + {{IDX_BITS{1'b0}}, 1'b1};

    acos_lut #(
        .IDX_BITS  (IDX_BITS),
        .DATA_W    (OUT_WIDTH),
        .OUT_SCALE (OUT_SCALE)
    ) u_lut (
        .clk_i       (clk_in),
        .rst_n_i     (rst_n_in),
        .rd_en_i     (adv_s),
        .rd_addr_a_i (addr_a_s),
        .rd_addr_b_i (addr_b_s),
        .rd_data_a_o (lut_a_s),
        .rd_data_b_o (lut_b_s)
    );

    // Stage 2: sideband travelling alongside the registered table reads.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid_q <= 1'b0;
            s2_frac_q  <= '0;
            s2_mode_q  <= MODE_ACOS;
            s2_tag_q   <= '0;
        end else if (adv_s) begin
            s2_valid_q <= s1_valid_q;
            s2_frac_q  <= s1_frac_q;
            s2_mode_q  <= s1_mode_q;
            s2_tag_q   <= s1_tag_q;
        end
    end

    // Slope is negative over the whole table, so the difference is signed.
    assign diff_s        = $signed(lut_b_s) - $signed(lut_a_s);
    assign frac_signed_s = $signed({1'b0, s2_frac_q});

    acos_interp_mul #(
        .A_W (OUT_WIDTH),
        .B_W (FRAC_BITS + 1)
    ) u_mul (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .en_i    (adv_s),
        .a_i     (diff_s),
        .b_i     (frac_signed_s),
        .p_o     (s3_prod_s)
    );

    // Stage 3: base entry and sideband registered alongside the product.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s3_valid_q <= 1'b0;
            s3_base_q  <= '0;
            s3_mode_q  <= MODE_ACOS;
            s3_tag_q   <= '0;
        end else if (adv_s) begin
            s3_valid_q <= s2_valid_q;
            s3_base_q  <= $signed(lut_a_s);
            s3_mode_q  <= s2_mode_q;
            s3_tag_q   <= s2_tag_q;
        end
    end

    // Stage 4 combinational: floor-scaled interpolation plus asin correction.
    always_comb begin
        interp_s = s3_base_q + OUT_WIDTH'(s3_prod_s >>> FRAC_BITS);
        result_d = interp_s;
        if (s3_mode_q == MODE_ASIN) begin
            result_d = HALF_SCALE - interp_s;
        end else begin
            result_d = interp_s;
        end
    end

    // Output register; held while the consumer is not ready.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
        end else if (adv_s) begin
            valid_q  <= s3_valid_q;
            result_q <= result_d;
            tag_q    <= s3_tag_q;
        end
    end

    assign valid_out  = valid_q;
    assign result_out = result_q;
    assign tag_out    = tag_q;

endmodule
